slow_timer: RTL and testbench

Consumer of the slow-peripheral settings register. Watches each bus cycle against the peripheral chip-selects and the per-device Slow* enable flags. On a qualifying access it holds the accelerator in slow mode for the whole access, then for a programmable tail of SlowTimeout prescaler ticks. Its SlowActive/SlowGateEN outputs feed the clock-switch and bus-timing logic.

---
 rtl/slow_timer.sv | 111 +++++++++++
 tb/tb_slow_timer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_timer.sv
// Slow-peripheral timer: holds SlowActive during a qualifying bus access and for a
// programmable tail of SlowTimeout prescaler ticks afterwards.
module slow_timer #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       SlowActive,
  output logic       SlowGateEN,
  output logic [3:0] SlowCount
);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StCount
  } stateT;

  stateT                 state, stateNext;
  logic [PRESCALE_W-1:0] prescaler, prescalerNext;
  logic [3:0]            countNext;
  logic                  hit;
  logic                  tick;
  logic                  activeNext;

  assign hit = BACT & ((IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                       (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd));
  assign tick = &prescaler;

  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    countNext     = SlowCount;
    unique case (state)
      StIdle: begin
        if (hit) begin
          stateNext     = StHold;
          countNext     = SlowTimeout;
          prescalerNext = '0;
        end
      end
      StHold: begin
        prescalerNext = '0;
        if (hit) begin
          countNext = SlowTimeout;
        end else if (SlowCount != 4'd0) begin
          stateNext = StCount;
        end else begin
          stateNext = StIdle;
        end
      end
      StCount: begin
        if (hit) begin
          // A new access outranks a tick landing on the same edge.
          stateNext     = StHold;
          countNext     = SlowTimeout;
          prescalerNext = '0;
        end else begin
          prescalerNext = prescaler + 1'b1;
          if (tick) begin
            if (SlowCount != 4'd0) begin
              countNext = SlowCount - 4'd1;
            end
            if (SlowCount <= 4'd1) begin
              stateNext = StIdle;
            end
          end
        end
      end
      default: begin
        stateNext     = StIdle;
        prescalerNext = '0;
        countNext     = 4'd0;
      end
    endcase
  end

  assign activeNext = (stateNext != StIdle);

  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      state      <= StIdle;
      prescaler  <= '0;
      SlowCount  <= 4'd0;
      SlowActive <= 1'b0;
      SlowGateEN <= 1'b0;
    end else begin
      state      <= stateNext;
      prescaler  <= prescalerNext;
      SlowCount  <= countNext;
      SlowActive <= activeNext;
      SlowGateEN <= activeNext & SlowClockGate;
    end
  end

endmodule

// File: tb/tb_slow_timer.sv
// Bench for slow_timer: directed scenarios plus random traffic against a cycle-count
// model of the slow window (PRESCALE_W = 2, one tick every 4 cycles).
module tb_slow_timer;

  localparam int unsigned PW   = 2;
  localparam int          TICK = 1 << PW;

  logic       CLK = 1'b0;
  logic       nPOR;
  logic       BACT;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowActive, SlowGateEN;
  logic [3:0] SlowCount;

  int passCount = 0;
  int totalCount = 0;

  // Model: window open while an access is seen, then a tail of SlowTimeout*TICK cycles.
  logic       mActive = 1'b0;
  logic       mGate = 1'b0;
  logic [3:0] mCount = 4'd0;
  logic       mInAccess = 1'b0;
  int         mLeft = 0;

  slow_timer #(.PRESCALE_W(PW)) dut (
    .CLK          (CLK),
    .nPOR         (nPOR),
    .BACT         (BACT),
    .IACKCS       (IACKCS),
    .VIACS        (VIACS),
    .IWMCS        (IWMCS),
    .SCCCS        (SCCCS),
    .SCSICS       (SCSICS),
    .SndCS        (SndCS),
    .SlowIACK     (SlowIACK),
    .SlowVIA      (SlowVIA),
    .SlowIWM      (SlowIWM),
    .SlowSCC      (SlowSCC),
    .SlowSCSI     (SlowSCSI),
    .SlowSnd      (SlowSnd),
    .SlowClockGate(SlowClockGate),
    .SlowTimeout  (SlowTimeout),
    .SlowActive   (SlowActive),
    .SlowGateEN   (SlowGateEN),
    .SlowCount    (SlowCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic busHit();
    return BACT && ((IACKCS && SlowIACK) || (VIACS && SlowVIA) || (IWMCS && SlowIWM) ||
                    (SCCCS && SlowSCC) || (SCSICS && SlowSCSI) || (SndCS && SlowSnd));
  endfunction

  // Advance one edge, update the model from the inputs that edge samples, settle.
  task automatic tick();
    @(posedge CLK);
    if (!nPOR) begin
      mActive = 1'b0; mInAccess = 1'b0; mLeft = 0; mCount = 4'd0;
    end else if (busHit()) begin
      mActive = 1'b1; mInAccess = 1'b1;
      mCount = SlowTimeout;
      mLeft = int'(SlowTimeout) * TICK;
    end else if (mInAccess) begin
      mInAccess = 1'b0;
      if (mLeft == 0) mActive = 1'b0;
    end else if (mActive) begin
      mLeft = mLeft - 1;
      mCount = 4'((mLeft + TICK - 1) / TICK);
      if (mLeft == 0) mActive = 1'b0;
    end
    mGate = mActive && SlowClockGate;
    #1;
  endtask

  task automatic clearBus();
    BACT = 1'b0;
    {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = 6'b0;
  endtask

  task automatic test_reset();
    clearBus();
    {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = 6'h3f;
    SlowTimeout = 4'd3; SlowClockGate = 1'b1;
    BACT = 1'b1; VIACS = 1'b1; nPOR = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      totalCount++;
      if ({SlowActive, SlowGateEN, SlowCount} !== 6'b0)
        $display("FAIL reset cyc %0d: act/gate/cnt %b/%b/%0d required 0/0/0",
                 i, SlowActive, SlowGateEN, SlowCount);
      else passCount++;
    end
    nPOR = 1'b1;
    tick();
    totalCount++;
    if (SlowActive !== 1'b1 || SlowCount !== 4'd3)
      $display("FAIL reset_release: act/cnt %b/%0d required 1/3", SlowActive, SlowCount);
    else passCount++;
    clearBus();
    for (int i = 0; i < 16; i++) tick();
    totalCount++;
    if (SlowActive !== mActive || SlowCount !== mCount)
      $display("FAIL reset_drain: act/cnt %b/%0d required %b/%0d",
               SlowActive, SlowCount, mActive, mCount);
    else passCount++;
  endtask

  task automatic test_via();
    int hi = 0;
    clearBus();
    SlowTimeout = 4'd3; SlowClockGate = 1'b1;
    BACT = 1'b1; VIACS = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      totalCount++;
      if (SlowActive !== 1'b1 || SlowGateEN !== 1'b1 || SlowCount !== 4'd3)
        $display("FAIL via_hold cyc %0d: act/gate/cnt %b/%b/%0d required 1/1/3",
                 i, SlowActive, SlowGateEN, SlowCount);
      else passCount++;
    end
    clearBus();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (SlowActive === 1'b1) hi++;
      totalCount++;
      if (SlowActive !== mActive || SlowGateEN !== mGate || SlowCount !== mCount)
        $display("FAIL via_tail cyc %0d: act/gate/cnt %b/%b/%0d required %b/%b/%0d",
                 i, SlowActive, SlowGateEN, SlowCount, mActive, mGate, mCount);
      else passCount++;
    end
    totalCount++;
    if (hi != 12) $display("FAIL via_tail_len: got %0d cycles required 12", hi);
    else passCount++;
  endtask

  task automatic test_ignored();
    clearBus();
    SlowSCSI = 1'b0; BACT = 1'b1; SCSICS = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        clearBus(); IWMCS = 1'b1; SlowIWM = 1'b1;
      end
      tick();
      totalCount++;
      if (SlowActive !== 1'b0 || SlowGateEN !== 1'b0)
        $display("FAIL ignored cyc %0d: act/gate %b/%b required 0/0",
                 i, SlowActive, SlowGateEN);
      else passCount++;
    end
    SlowSCSI = 1'b1;
    clearBus();
  endtask

  task automatic test_timeout_zero();
    int hi = 0;
    clearBus();
    SlowTimeout = 4'd0; BACT = 1'b1; SCCCS = 1'b1;
    totalCount++;
    if (SlowActive !== 1'b0) $display("FAIL zero_pre: act %b required 0", SlowActive);
    else passCount++;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 2) clearBus();
      if (SlowActive === 1'b1) hi++;
      totalCount++;
      if (SlowActive !== mActive || SlowCount !== mCount)
        $display("FAIL zero cyc %0d: act/cnt %b/%0d required %b/%0d",
                 i, SlowActive, SlowCount, mActive, mCount);
      else passCount++;
    end
    totalCount++;
    if (hi != 3) $display("FAIL zero_len: got %0d cycles required 3", hi);
    else passCount++;
  endtask

  task automatic test_retrigger();
    int hi = 0;
    clearBus();
    SlowTimeout = 4'd2; BACT = 1'b1; VIACS = 1'b1;
    tick();
    clearBus();
    for (int i = 0; i < 8; i++) begin
      tick();
      totalCount++;
      if (SlowActive !== 1'b1 || SlowCount !== mCount)
        $display("FAIL retrig_tail1 cyc %0d: act/cnt %b/%0d required 1/%0d",
                 i, SlowActive, SlowCount, mCount);
      else passCount++;
    end
    BACT = 1'b1; VIACS = 1'b1;
    tick();
    totalCount++;
    if (SlowActive !== 1'b1 || SlowCount !== 4'd2)
      $display("FAIL retrig_edge: act/cnt %b/%0d required 1/2", SlowActive, SlowCount);
    else passCount++;
    clearBus();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (SlowActive === 1'b1) hi++;
    end
    totalCount++;
    if (hi != 8) $display("FAIL retrig_tail2_len: got %0d cycles required 8", hi);
    else passCount++;
  endtask

  task automatic test_mid_count();
    int hi = 0;
    clearBus();
    SlowTimeout = 4'd2; BACT = 1'b1; VIACS = 1'b1;
    tick(); tick();
    clearBus();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) SlowTimeout = 4'hf;
      if (SlowActive === 1'b1) hi++;
    end
    totalCount++;
    if (hi != 8) $display("FAIL midcount_timeout: got %0d cycles required 8", hi);
    else passCount++;
    SlowTimeout = 4'd3; BACT = 1'b1; VIACS = 1'b1;
    tick();
    clearBus();
    for (int i = 0; i < 3; i++) tick();
    nPOR = 1'b0;
    tick();
    nPOR = 1'b1;
    totalCount++;
    if ({SlowActive, SlowGateEN, SlowCount} !== 6'b0)
      $display("FAIL midcount_reset: act/gate/cnt %b/%b/%0d required 0/0/0",
               SlowActive, SlowGateEN, SlowCount);
    else passCount++;
    tick();
    totalCount++;
    if (SlowActive !== 1'b0)
      $display("FAIL midcount_reset_notail: act %b required 0", SlowActive);
    else passCount++;
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        clearBus();
        BACT = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 6))
          0: IACKCS = 1'b1;
          1: VIACS  = 1'b1;
          2: IWMCS  = 1'b1;
          3: SCCCS  = 1'b1;
          4: SCSICS = 1'b1;
          5: SndCS  = 1'b1;
          default: BACT = 1'b0;
        endcase
        {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = 6'($urandom) | 6'($urandom);
        hold = $urandom_range(1, 14);
      end
      hold--;
      SlowTimeout = 4'($urandom_range(0, 3));
      SlowClockGate = ($urandom_range(0, 5) != 0);
      nPOR = ($urandom_range(0, 79) != 0);
      tick();
      totalCount++;
      if (SlowActive !== mActive || SlowGateEN !== mGate || SlowCount !== mCount)
        $display("FAIL random cyc %0d: act/gate/cnt %b/%b/%0d required %b/%b/%0d",
                 i, SlowActive, SlowGateEN, SlowCount, mActive, mGate, mCount);
      else passCount++;
    end
    nPOR = 1'b1;
    clearBus();
  endtask

  initial begin
    nPOR = 1'b0;
    clearBus();
    {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = 6'h3f;
    SlowClockGate = 1'b1;
    SlowTimeout = 4'd0;
    @(negedge CLK);
    test_reset();
    test_via();
    test_ignored();
    test_timeout_zero();
    test_retrigger();
    test_mid_count();
    test_random();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
